// File: rtl/exmem_pf_pkg.sv
// Shared types and constants for the exmem Wishbone front-end with next-word prefetch.
package exmem_pf_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDemand,
    StResp,
    StPrefetch,
    StPfWait,
    StAbort
  } pf_state_e;

  localparam logic [31:0] DefaultBaseAddr = 32'h3800_0000;
  localparam logic [31:0] DefaultAddrMask = 32'hFFC0_0000;
  localparam logic [31:0] WordIncr        = 32'd4;

endpackage

// File: rtl/exmem_prefetch_if.sv
// Upstream Wishbone slave signals and downstream exmem handshake, bundled for the front-end.
interface exmem_prefetch_if;

  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  logic        mem_valid;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_adr;
  logic [31:0] mem_dat_o;
  logic        mem_ack;
  logic [31:0] mem_dat_i;

  // Front-end view: slave on Wishbone, requester towards exmem.
  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output mem_valid, mem_we, mem_sel, mem_adr, mem_dat_o,
    input  mem_ack, mem_dat_i
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  mem_valid, mem_we, mem_sel, mem_adr, mem_dat_o,
    output mem_ack, mem_dat_i
  );

endinterface

// File: rtl/exmem_pf_line.sv
// One-word prefetch buffer: valid flag, word address and data, with fill/invalidate/compare.
module exmem_pf_line (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        fill_i,
  input  logic [29:0] fill_adr_i,
  input  logic [31:0] fill_dat_i,
  input  logic        inval_i,
  input  logic [29:0] cmp_adr_i,
  output logic        match_o,
  output logic        vld_o,
  output logic [29:0] adr_o,
  output logic [31:0] dat_o
);

  logic        vld_q;
  logic [29:0] adr_q;
  logic [31:0] dat_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      vld_q <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
    end else if (fill_i) begin
      vld_q <= 1'b1;
      adr_q <= fill_adr_i;
      dat_q <= fill_dat_i;
    end else if (inval_i) begin
      vld_q <= 1'b0;
    end
  end

  // Address match only; the caller qualifies with vld_o.
  assign match_o = (adr_q == cmp_adr_i);
  assign vld_o   = vld_q;
  assign adr_o   = adr_q;
  assign dat_o   = dat_q;

endmodule

// File: rtl/exmem_prefetch.sv
// Wishbone front-end for exmem: window decode, valid/ack conversion and next-word prefetch.
module exmem_prefetch
  import exmem_pf_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DefaultBaseAddr,
  parameter logic [31:0] ADDR_MASK   = DefaultAddrMask,
  parameter bit          PREFETCH_EN = 1'b1
) (
  input logic              wb_clk_i,
  input logic              wb_rst_i,
  exmem_prefetch_if.slave  bus
);

  pf_state_e   state_q, state_d;
  logic        ack_q, ack_d;
  logic [31:0] rdat_q, rdat_d;
  logic        mv_q, mv_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] last_adr_q, last_adr_d;
  logic        last_we_q, last_we_d;

  logic        req, rd_req, pf_match;
  logic        fill, inval;
  logic        pf_vld, line_match;
  logic [29:0] pf_adr;
  logic [31:0] pf_dat;

  assign req      = bus.wbs_cyc_i & bus.wbs_stb_i & ((bus.wbs_adr_i & ADDR_MASK) == BASE_ADDR);
  assign rd_req   = req & ~bus.wbs_we_i;
  // In PREFETCH adr_q holds the speculative address.
  assign pf_match = rd_req && (bus.wbs_adr_i[31:2] == adr_q[31:2]);

  exmem_pf_line u_line (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .fill_i     (fill),
    .fill_adr_i (adr_q[31:2]),
    .fill_dat_i (bus.mem_dat_i),
    .inval_i    (inval),
    .cmp_adr_i  (bus.wbs_adr_i[31:2]),
    .match_o    (line_match),
    .vld_o      (pf_vld),
    .adr_o      (pf_adr),
    .dat_o      (pf_dat)
  );

  always_comb begin
    state_d    = state_q;
    ack_d      = 1'b0;
    rdat_d     = rdat_q;
    mv_d       = mv_q;
    we_d       = we_q;
    sel_d      = sel_q;
    adr_d      = adr_q;
    wdat_d     = wdat_q;
    last_adr_d = last_adr_q;
    last_we_d  = last_we_q;
    fill       = 1'b0;
    inval      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rd_req && pf_vld && line_match) begin
          state_d    = StResp;
          ack_d      = 1'b1;
          rdat_d     = pf_dat;
          inval      = 1'b1;
          last_adr_d = bus.wbs_adr_i;
          last_we_d  = 1'b0;
        end else if (req) begin
          state_d    = StDemand;
          mv_d       = 1'b1;
          we_d       = bus.wbs_we_i;
          sel_d      = bus.wbs_sel_i;
          adr_d      = bus.wbs_adr_i;
          wdat_d     = bus.wbs_dat_i;
          last_adr_d = bus.wbs_adr_i;
          last_we_d  = bus.wbs_we_i;
        end
      end
      StDemand: begin
        if (bus.mem_ack) begin
          mv_d  = 1'b0;
          inval = we_q && (adr_q[31:2] == pf_adr);
          if (bus.wbs_cyc_i) begin
            state_d = StResp;
            ack_d   = 1'b1;
            if (!we_q) rdat_d = bus.mem_dat_i;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StResp: begin
        if (!last_we_q && PREFETCH_EN) begin
          state_d = StPrefetch;
          mv_d    = 1'b1;
          we_d    = 1'b0;
          sel_d   = 4'hF;
          adr_d   = last_adr_q + WordIncr;
        end else begin
          state_d = StIdle;
        end
      end
      StPrefetch: begin
        if (bus.mem_ack) begin
          mv_d    = 1'b0;
          fill    = 1'b1;
          state_d = StIdle;
        end else if (pf_match) begin
          state_d    = StPfWait;
          last_adr_d = adr_q;
          last_we_d  = 1'b0;
        end else if (req) begin
          // Drop valid for a cycle so exmem restarts its delay count.
          mv_d    = 1'b0;
          state_d = StAbort;
        end
      end
      StPfWait: begin
        if (bus.mem_ack) begin
          mv_d = 1'b0;
          if (bus.wbs_cyc_i) begin
            state_d = StResp;
            ack_d   = 1'b1;
            rdat_d  = bus.mem_dat_i;
          end else begin
            fill    = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StAbort: begin
        if (req) begin
          state_d    = StDemand;
          mv_d       = 1'b1;
          we_d       = bus.wbs_we_i;
          sel_d      = bus.wbs_sel_i;
          adr_d      = bus.wbs_adr_i;
          wdat_d     = bus.wbs_dat_i;
          last_adr_d = bus.wbs_adr_i;
          last_we_d  = bus.wbs_we_i;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= StIdle;
      ack_q      <= 1'b0;
      rdat_q     <= '0;
      mv_q       <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      adr_q      <= '0;
      wdat_q     <= '0;
      last_adr_q <= '0;
      last_we_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      rdat_q     <= rdat_d;
      mv_q       <= mv_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      adr_q      <= adr_d;
      wdat_q     <= wdat_d;
      last_adr_q <= last_adr_d;
      last_we_q  <= last_we_d;
    end
  end

  assign bus.wbs_ack_o = ack_q;
  assign bus.wbs_dat_o = rdat_q;
  assign bus.mem_valid = mv_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_sel   = sel_q;
  assign bus.mem_adr   = adr_q;
  assign bus.mem_dat_o = wdat_q;

endmodule

// File: tb/tb_exmem_prefetch.sv
// Bench for exmem_prefetch: behavioural exmem (DELAYS=10), directed vectors and random traffic.
module tb_exmem_prefetch;
  import exmem_pf_pkg::*;

  localparam int unsigned Delays = 10;

  logic wb_clk_i = 1'b0;
  logic wb_rst_i = 1'b1;
  logic mem_clr  = 1'b1;

  exmem_prefetch_if bus ();

  exmem_prefetch dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .bus      (bus)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  function automatic logic [31:0] init_word(int unsigned i);
    return 32'h5A00_0000 ^ (i * 32'h0001_0203);
  endfunction

  // Behavioural exmem: acks after Delays cycles of continuous valid.
  logic [31:0] mem_arr [1024];
  int unsigned cnt;
  logic        mem_ack;

  assign mem_ack       = bus.mem_valid && (cnt == Delays);
  assign bus.mem_ack   = mem_ack;
  assign bus.mem_dat_i = mem_arr[bus.mem_adr[11:2]];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) cnt <= 0;
    else if (bus.mem_valid && !mem_ack) cnt <= cnt + 1;
    else cnt <= 0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem_arr[i] <= init_word(i);
    end else if (mem_ack && bus.mem_we) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_sel[b]) mem_arr[bus.mem_adr[11:2]][8*b +: 8] <= bus.mem_dat_o[8*b +: 8];
    end
  end

  // Reference memory: what a plain (non-prefetching) memory would return.
  logic [31:0] shadow [1024];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic shadow_write(input logic [31:0] adr, input logic [3:0] sel,
                              input logic [31:0] dat);
    for (int b = 0; b < 4; b++)
      if (sel[b]) shadow[adr[11:2]][8*b +: 8] = dat[8*b +: 8];
  endtask

  task automatic idle_bus();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge of the ack cycle (or after budget).
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] wdat, input int budget, output int lat,
                      output logic [31:0] rdat, output logic mv1, output logic [31:0] adr1,
                      output logic mv2, output logic [31:0] adr2, output logic mv_any);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = sel;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = wdat;
    lat = 0; rdat = '0; mv1 = 1'b0; mv2 = 1'b0; adr1 = '0; adr2 = '0; mv_any = 1'b0;
    for (int n = 1; n <= budget; n++) begin
      @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      if (n == 1) begin mv1 = bus.mem_valid; adr1 = bus.mem_adr; end
      if (n == 2) begin mv2 = bus.mem_valid; adr2 = bus.mem_adr; end
      if (bus.mem_valid) mv_any = 1'b1;
      if (bus.wbs_ack_o) begin
        lat  = n;
        rdat = bus.wbs_dat_o;
        break;
      end
    end
    idle_bus();
    if (lat != 0 && we) shadow_write(adr, sel, wdat);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          exp_lat;
    logic        exp_pf;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int          lat;
    logic [31:0] rdat, adr1, adr2, exp;
    logic        mv1, mv2, mv_any;
    logic [31:0] prev;

    vecs[0]  = '{1'b0, 32'h3800_0000, 4'hF, 32'h0,         12, 1'b1};
    vecs[1]  = '{1'b0, 32'h3800_0004, 4'hF, 32'h0,          1, 1'b1};
    vecs[2]  = '{1'b1, 32'h3800_0008, 4'hF, 32'hDEAD_BEEF, 12, 1'b0};
    vecs[3]  = '{1'b0, 32'h3800_0008, 4'hF, 32'h0,         12, 1'b1};
    vecs[4]  = '{1'b0, 32'h3800_000C, 4'hF, 32'h0,          1, 1'b1};
    vecs[5]  = '{1'b1, 32'h3800_0010, 4'h3, 32'h1234_5678, 12, 1'b0};
    vecs[6]  = '{1'b0, 32'h3800_0010, 4'hF, 32'h0,         12, 1'b1};
    vecs[7]  = '{1'b0, 32'h3800_0020, 4'hF, 32'h0,         12, 1'b1};
    vecs[8]  = '{1'b0, 32'h3000_0000, 4'hF, 32'h0,          0, 1'b1};
    vecs[9]  = '{1'b0, 32'h3800_0024, 4'hF, 32'h0,          1, 1'b1};
    vecs[10] = '{1'b1, 32'h3800_0100, 4'h8, 32'hAB00_0000, 12, 1'b1};

    for (int i = 0; i < 1024; i++) shadow[i] = init_word(i);
    idle_bus();
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
    repeat (3) @(negedge wb_clk_i);
    mem_clr  = 1'b0;
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);

    check("reset_ack", 32'(bus.wbs_ack_o), 32'd0);
    check("reset_mem_valid", 32'(bus.mem_valid), 32'd0);
    check("reset_mem_adr", bus.mem_adr, 32'd0);
    check("reset_pf_vld", 32'(dut.pf_vld), 32'd0);
    check("reset_state", 32'(dut.state_q), 32'(StIdle));

    // Directed vectors, each from a quiet bus with any prefetch already landed.
    for (int i = 0; i < 11; i++) begin
      xfer(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, 20,
           lat, rdat, mv1, adr1, mv2, adr2, mv_any);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      if (vecs[i].exp_lat == 0) begin
        check($sformatf("v%0d_no_mem_valid", i), 32'(mv_any), 32'd0);
      end else if (vecs[i].exp_lat == 1) begin
        check($sformatf("v%0d_hit_no_mem_valid", i), 32'(mv_any), 32'd0);
      end else begin
        check($sformatf("v%0d_mem_valid_c1", i), 32'(mv1), 32'd1);
        check($sformatf("v%0d_mem_adr_c1", i), adr1, vecs[i].adr);
      end
      if (vecs[i].exp_lat != 0 && !vecs[i].we)
        check($sformatf("v%0d_rdata", i), rdat, shadow[vecs[i].adr[11:2]]);
      @(negedge wb_clk_i);
      if (vecs[i].exp_lat != 0 && !vecs[i].we) begin
        check($sformatf("v%0d_pf_issue", i), 32'(bus.mem_valid), 32'd1);
        check($sformatf("v%0d_pf_adr", i), bus.mem_adr, vecs[i].adr + 32'd4);
      end else begin
        check($sformatf("v%0d_no_pf_issue", i), 32'(bus.mem_valid), 32'd0);
      end
      repeat (14) @(negedge wb_clk_i);
      check($sformatf("v%0d_pf_vld", i), 32'(dut.pf_vld), 32'(vecs[i].exp_pf));
    end

    // Mismatching read mid-prefetch: one idle cycle, then the demand transfer.
    xfer(1'b0, 32'h3800_0040, 4'hF, 32'h0, 20, lat, rdat, mv1, adr1, mv2, adr2, mv_any);
    check("abort_pre_latency", 32'(lat), 32'd12);
    repeat (3) @(negedge wb_clk_i);
    check("abort_pf_busy", 32'(bus.mem_valid), 32'd1);
    xfer(1'b0, 32'h3800_0100, 4'hF, 32'h0, 20, lat, rdat, mv1, adr1, mv2, adr2, mv_any);
    check("abort_latency", 32'(lat), 32'd13);
    check("abort_gap", 32'(mv1), 32'd0);
    check("abort_demand_valid", 32'(mv2), 32'd1);
    check("abort_demand_adr", adr2, 32'h3800_0100);
    check("abort_rdata", rdat, shadow[32'h100 >> 2]);
    repeat (15) @(negedge wb_clk_i);

    // Request to the in-flight prefetch address, held through RESP: served by PF_WAIT.
    xfer(1'b0, 32'h3800_0060, 4'hF, 32'h0, 20, lat, rdat, mv1, adr1, mv2, adr2, mv_any);
    check("pfwait_pre_latency", 32'(lat), 32'd12);
    xfer(1'b0, 32'h3800_0064, 4'hF, 32'h0, 20, lat, rdat, mv1, adr1, mv2, adr2, mv_any);
    check("pfwait_latency", 32'(lat), 32'd12);
    check("pfwait_issue_adr", adr1, 32'h3800_0064);
    check("pfwait_rdata", rdat, shadow[32'h64 >> 2]);
    repeat (15) @(negedge wb_clk_i);

    // Master abandons a demand read: no ack, FSM back to idle.
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_adr_i = 32'h3800_0200;
    repeat (4) @(negedge wb_clk_i);
    idle_bus();
    mv_any = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge wb_clk_i);
      if (bus.wbs_ack_o) mv_any = 1'b1;
    end
    check("cyc_drop_no_ack", 32'(mv_any), 32'd0);
    check("cyc_drop_state", 32'(dut.state_q), 32'(StIdle));
    check("cyc_drop_mem_valid", 32'(bus.mem_valid), 32'd0);

    // Reset pulsed during a demand transfer.
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = 32'h3800_0300;
    bus.wbs_dat_i = 32'hCAFE_F00D;
    repeat (3) @(negedge wb_clk_i);
    check("rst_pre_state", 32'(dut.state_q), 32'(StDemand));
    wb_rst_i = 1'b1;
    idle_bus();
    #1;
    check("rst_async_mem_valid", 32'(bus.mem_valid), 32'd0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    check("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
    check("rst_dat", bus.wbs_dat_o, 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_sel", 32'(bus.mem_sel), 32'd0);
    check("rst_mem_adr", bus.mem_adr, 32'd0);
    check("rst_mem_dat", bus.mem_dat_o, 32'd0);
    check("rst_pf_vld", 32'(dut.pf_vld), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(StIdle));
    @(negedge wb_clk_i);

    // Random traffic: mostly sequential reads, some writes, varied gaps.
    prev = 32'h3800_0000;
    for (int t = 0; t < 60; t++) begin
      logic        we;
      logic [31:0] adr;
      logic [3:0]  sel;
      logic [31:0] dat;
      we  = ($urandom_range(0, 3) == 0);
      adr = ($urandom_range(0, 1) == 0) ? prev + 32'd4
                                        : 32'h3800_0000 + 32'($urandom_range(0, 255) * 4);
      adr = 32'h3800_0000 | {20'd0, adr[11:2], 2'b00};
      sel = we ? 4'($urandom_range(1, 15)) : 4'hF;
      dat = $urandom;
      exp = shadow[adr[11:2]];
      xfer(we, adr, sel, dat, 40, lat, rdat, mv1, adr1, mv2, adr2, mv_any);
      check($sformatf("rnd%0d_acked", t), 32'(lat != 0), 32'd1);
      if (!we && lat != 0) check($sformatf("rnd%0d_rdata", t), rdat, exp);
      prev = adr;
      repeat ($urandom_range(0, 14)) @(negedge wb_clk_i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
